// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   tx_start, tx_data            request pulse and the byte to send
//   ps2_clk_in, ps2_data_in      raw (asynchronous) PS/2 pin levels
//   ps2_clk_low, ps2_data_low    open-drain enables (1 = pull the line low)
//   tx_busy, tx_done, tx_error   transfer status and completion pulses
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int SETUP_CYCLES   = 200,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int DLY_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ?
                             INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int DW = $clog2(DLY_MAX) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int FW = $clog2(FILTER_LEN) + 1;

    localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
    localparam logic [DW-1:0] SET_LAST = DW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] fcnt;
    logic          fall;

    logic [2:0]    state;
    logic [DW-1:0] dly;
    logic [TW-1:0] to_cnt;
    logic [3:0]    bitcnt;
    logic [8:0]    shreg;
    logic          to_hit;

    // Pin synchronizers and clk glitch filter; idle bus level is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            fcnt     <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (fcnt == FLT_LAST) begin
                    filt_clk <= clk_s2;
                    fcnt     <= '0;
                    fall     <= ~clk_s2;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign to_hit = (to_cnt == TO_LAST);

    // shreg holds {parity, data}; each fall puts shreg[0] on the line and
    // shifts in a 1, so the tenth fall releases data for the stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            dly          <= '0;
            to_cnt       <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start coinciding with the completion pulse is dropped.
                    if (tx_start && !tx_done && !tx_error) begin
                        shreg       <= {~^tx_data, tx_data};
                        tx_busy     <= 1'b1;
                        ps2_clk_low <= 1'b1;
                        dly         <= '0;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (dly == INH_LAST) begin
                        dly          <= '0;
                        ps2_data_low <= 1'b1;
                        state        <= S_SETUP;
                    end else begin
                        dly <= dly + DW'(1);
                    end
                end
                S_SETUP: begin
                    if (dly == SET_LAST) begin
                        dly         <= '0;
                        ps2_clk_low <= 1'b0;
                        bitcnt      <= '0;
                        to_cnt      <= '0;
                        state       <= S_SEND;
                    end else begin
                        dly <= dly + DW'(1);
                    end
                end
                S_SEND: begin
                    if (fall) begin
                        to_cnt       <= '0;
                        ps2_data_low <= ~shreg[0];
                        shreg        <= {1'b1, shreg[8:1]};
                        if (bitcnt != 4'd10) begin
                            bitcnt <= bitcnt + 4'd1;
                        end
                        if (bitcnt == 4'd9) begin
                            state <= S_ACK;
                        end
                    end else if (to_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (!dat_s2) begin
                            state <= S_WAIT;
                        end else begin
                            tx_error <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else if (to_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (filt_clk && dat_s2) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end else if (to_hit) begin
                        tx_error     <= 1'b1;
                        tx_busy      <= 1'b0;
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    tx_busy      <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model on a wired-AND bus,
// with frame and outcome scoreboards checked by a monitor process.
module tb_ps2_host_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .SETUP_CYCLES(10),
        .FILTER_LEN(2),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_low(ps2_clk_low),
        .ps2_data_low(ps2_data_low),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int applied = 0;
    int miscompares = 0;

    logic [10:0] frame_q[$];
    int          out_q[$];
    logic [10:0] rx_frame = '0;
    logic        rx_stb = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: pops expectations whenever the device model reports a frame
    // or the DUT reports an outcome (1 = done, 2 = error).
    always @(negedge clock) begin
        if (rx_stb) begin
            if (frame_q.size() == 0) fail("unexpected_frame");
            else check("frame", 32'(rx_frame), 32'(frame_q.pop_front()));
        end
        if (!reset && (tx_done || tx_error)) begin
            check("done_error_exclusive", 32'(tx_done & tx_error), 0);
            if (out_q.size() == 0) fail("unexpected_outcome");
            else check("outcome", tx_done ? 1 : 2, out_q.pop_front());
        end
    end

    initial begin
        repeat (95000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Device: samples start on host clk release, then clocks 10 bits at a
    // 400-cycle period, sampling on rising edges, then the ACK clock.
    task automatic dev_xfer(input int nack, input int abort_fall);
        logic [10:0] frame;
        bit seen;
        frame = '0;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            seen = (ps2_data_in == 1'b0) && (ps2_clk_in == 1'b0);
        end
        if (!seen) begin
            fail("dev_wait_setup");
            return;
        end
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clock);
            seen = (ps2_clk_in == 1'b1);
        end
        if (!seen) begin
            fail("dev_wait_release");
            return;
        end
        frame[0] = ps2_data_in;
        repeat (100) @(negedge clock);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            if (i == abort_fall) return;
            repeat (200) @(negedge clock);
            dev_clk_low = 1'b0;
            frame[i] = ps2_data_in;
            repeat (200) @(negedge clock);
        end
        if (nack == 0) dev_data_low = 1'b1;
        repeat (50) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (200) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clock);
        dev_data_low = 1'b0;
        @(posedge clock);
        rx_frame = frame;
        rx_stb = 1'b1;
        @(posedge clock);
        rx_stb = 1'b0;
    endtask

    task automatic start(input logic [7:0] b);
        @(negedge clock);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check("busy_after_start", 32'(tx_busy), 1);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clock);
            seen = (tx_busy == 1'b0);
        end
        if (!seen) fail("busy_timeout");
    endtask

    task automatic xfer(input logic [7:0] b, input logic [10:0] exp_frame,
                        input int nack);
        frame_q.push_back(exp_frame);
        out_q.push_back(nack == 0 ? 1 : 2);
        start(b);
        dev_xfer(nack, 0);
        wait_idle();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_clk_low"}, 32'(ps2_clk_low), 0);
        check({tag, "_data_low"}, 32'(ps2_data_low), 0);
        check({tag, "_busy"}, 32'(tx_busy), 0);
        check({tag, "_done"}, 32'(tx_done), 0);
        check({tag, "_error"}, 32'(tx_error), 0);
    endtask

    initial begin
        int t_rel;
        bit seen;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Frames are {stop, parity, data, start}.
        xfer(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 0);
        xfer(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 0);
        xfer(8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 0);

        // Silent device: timeout counted from clk release.
        out_q.push_back(2);
        start(8'hF4);
        t_rel = 0;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            if (ps2_clk_low == 1'b0) begin
                seen = 1;
                t_rel = cyc;
            end
        end
        if (!seen) fail("release_wait");
        seen = 0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clock);
            seen = (tx_error == 1'b1);
        end
        if (!seen) fail("timeout_wait");
        else check("timeout_latency", cyc - t_rel, 5000);
        @(negedge clock);
        check("to_clk_low", 32'(ps2_clk_low), 0);
        check("to_data_low", 32'(ps2_data_low), 0);
        check("to_busy", 32'(tx_busy), 0);
        repeat (10) @(negedge clock);

        // Missing ACK.
        xfer(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1);
        check("nack_state_idle", 32'(dut.state), 0);
        repeat (10) @(negedge clock);

        // Second start mid-transfer is ignored.
        frame_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
        out_q.push_back(1);
        start(8'hED);
        fork
            dev_xfer(0, 0);
            begin
                repeat (2000) @(negedge clock);
                tx_data = 8'hFF;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
                tx_data = 8'h00;
            end
        join
        wait_idle();
        xfer(8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 0);

        // Reset at device fall 5.
        start(8'hF4);
        dev_xfer(0, 5);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_quiet("midreset");
        dev_clk_low = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        xfer(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 0);

        repeat (20) @(negedge clock);
        check("frames_left", frame_q.size(), 0);
        check("outcomes_left", out_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
